// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types, constants and pad helper for the Ascon bdi feeder
package ascon_pkg;

    localparam int CCW    = 32;
    localparam int LANES  = CCW / 8;
    localparam int LANE_W = $clog2(LANES + 1);

    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [3:0] {
        D_NULL  = 4'd0,
        D_NONCE = 4'd1,
        D_AD    = 4'd2,
        D_MSG   = 4'd3,
        D_TAG   = 4'd4
    } bdi_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_PAD  = 2'd2
    } pad_state_e;

    // Places PAD_BYTE in the first empty lane; lane == LANES leaves the word untouched.
    function automatic logic [CCW-1:0] pad_merge(input logic [CCW-1:0] word,
                                                 input logic [LANE_W-1:0] lane);
        logic [CCW-1:0] w;
        w = word;
        for (int k = 0; k < LANES; k++) begin
            if (lane == LANE_W'(k)) begin
                w[CCW-1-8*k -: 8] = PAD_BYTE;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ascon_byte_packer.sv
// rtl/ascon_byte_packer.sv - MSB-first byte accumulator with lane counter
// drop discards the held bytes before this cycle's push; take clears after it.
module ascon_byte_packer
    import ascon_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              drop,
    input  logic              push,
    input  logic              take,
    input  logic [7:0]        din,
    output logic [CCW-1:0]    word,
    output logic [LANE_W-1:0] lane,
    output logic [CCW-1:0]    nxt_word,
    output logic [LANE_W-1:0] nxt_lane
);

    logic [CCW-1:0]    acc_q, acc_d;
    logic [LANE_W-1:0] cnt_q, cnt_d;

    always_comb begin : insert_byte
        nxt_word = drop ? '0 : acc_q;
        nxt_lane = drop ? '0 : cnt_q;
        for (int k = 0; k < LANES; k++) begin
            if (push && nxt_lane == LANE_W'(k)) begin
                nxt_word[CCW-1-8*k -: 8] = din;
            end
        end
        if (push) begin
            nxt_lane = nxt_lane + LANE_W'(1);
        end
    end

    always_comb begin : update
        acc_d = take ? '0 : nxt_word;
        cnt_d = take ? '0 : nxt_lane;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign word = acc_q;
    assign lane = cnt_q;

endmodule

// File: rtl/ascon_bdi_padder.sv
// rtl/ascon_bdi_padder.sv - segment packer and 10* padder feeding the Ascon core bdi port
// Optional header checking and sticky err port: ASCON_PADDER_CHECK_EN.
module ascon_bdi_padder
    import ascon_pkg::*;
#(
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          hdr_type,
    input  logic [LEN_BITS-1:0] hdr_len,
    input  logic                hdr_eoi,
    input  logic                hdr_valid,
    output logic                hdr_ready,
    input  logic [7:0]          din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [CCW-1:0]      bdi,
    output logic                bdi_valid,
    input  logic                bdi_ready,
    output logic [3:0]          bdi_type,
    output logic                bdi_eot,
    output logic                bdi_eoi
`ifdef ASCON_PADDER_CHECK_EN
    ,
    output logic                err
`endif
);

    pad_state_e state_q, state_d;

    logic [3:0]          type_q, type_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d, cnt_inc;
    logic                eoi_q, eoi_d;

    logic [CCW-1:0] bdi_q, bdi_d;
    logic           bdi_valid_q, bdi_valid_d;
    logic [3:0]     bdi_type_q, bdi_type_d;
    logic           bdi_eot_q, bdi_eot_d;
    logic           bdi_eoi_q, bdi_eoi_d;

    logic out_free, is_nt, bytes_left, seg_end;
    logic hdr_acc, push, drop, take, load;
    logic load_eot, load_eoi;

    logic [CCW-1:0]    pk_word, pk_nxt_word, load_word;
    logic [LANE_W-1:0] pk_lane, pk_nxt_lane, pk_after;

    ascon_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .drop     (drop),
        .push     (push),
        .take     (take),
        .din      (din),
        .word     (pk_word),
        .lane     (pk_lane),
        .nxt_word (pk_nxt_word),
        .nxt_lane (pk_nxt_lane)
    );

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs; drop means the held word moves to the output register this cycle.
    always_comb begin : fsm_outputs
        out_free   = !bdi_valid_q || bdi_ready;
        is_nt      = (type_q == D_NONCE) || (type_q == D_TAG);
        bytes_left = (cnt_q != len_q);
        hdr_ready  = 1'b0;
        din_ready  = 1'b0;
        drop       = 1'b0;
        case (state_q)
            ST_IDLE: hdr_ready = !rst;
            ST_PACK: begin
                din_ready = !rst && bytes_left && !(pk_lane == LANE_W'(LANES) && !out_free);
                drop      = out_free && (pk_lane == LANE_W'(LANES) ||
                                         (!bytes_left && pk_lane != '0 && is_nt));
            end
            ST_PAD:  drop = out_free;
            default: ;
        endcase
        hdr_acc = hdr_valid && hdr_ready;
        push    = din_valid && din_ready;
    end

    always_comb begin : datapath
        cnt_inc = push ? cnt_q + LEN_BITS'(1) : cnt_q;
        seg_end = (cnt_inc == len_q);
        // A completing byte bypasses the accumulator when the output register is free.
        take = (state_q == ST_PACK) && push && !drop && out_free &&
               (pk_nxt_lane == LANE_W'(LANES) || (is_nt && seg_end));
        pk_after = take ? '0 : pk_nxt_lane;
        load     = drop || take;

        if (take) begin
            load_word = pk_nxt_word;
        end else if (state_q == ST_PAD) begin
            load_word = pad_merge(pk_word, pk_lane);
        end else begin
            load_word = pk_word;
        end
        load_eot = (state_q == ST_PAD) || (is_nt && seg_end && pk_after == '0);
        load_eoi = load_eot && eoi_q &&
                   (type_q == D_NONCE || type_q == D_AD || type_q == D_MSG);

        type_d = type_q;
        len_d  = len_q;
        eoi_d  = eoi_q;
        cnt_d  = cnt_inc;
        if (hdr_acc) begin
            type_d = hdr_type;
            len_d  = hdr_len;
            eoi_d  = hdr_eoi;
            cnt_d  = '0;
        end

        bdi_d       = bdi_q;
        bdi_type_d  = bdi_type_q;
        bdi_eot_d   = bdi_eot_q;
        bdi_eoi_d   = bdi_eoi_q;
        bdi_valid_d = bdi_valid_q && !bdi_ready;
        if (load) begin
            bdi_d       = load_word;
            bdi_type_d  = type_q;
            bdi_eot_d   = load_eot;
            bdi_eoi_d   = load_eoi;
            bdi_valid_d = 1'b1;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_acc && hdr_len != '0) begin
                    state_d = ST_PACK;
                end
            end
            ST_PACK: begin
                if (is_nt) begin
                    if (load && load_eot) begin
                        state_d = ST_IDLE;
                    end
                end else if (seg_end && pk_after != LANE_W'(LANES)) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                if (load) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type_q      <= D_NULL;
            len_q       <= '0;
            cnt_q       <= '0;
            eoi_q       <= 1'b0;
            bdi_q       <= '0;
            bdi_valid_q <= 1'b0;
            bdi_type_q  <= D_NULL;
            bdi_eot_q   <= 1'b0;
            bdi_eoi_q   <= 1'b0;
        end else begin
            type_q      <= type_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            eoi_q       <= eoi_d;
            bdi_q       <= bdi_d;
            bdi_valid_q <= bdi_valid_d;
            bdi_type_q  <= bdi_type_d;
            bdi_eot_q   <= bdi_eot_d;
            bdi_eoi_q   <= bdi_eoi_d;
        end
    end

    assign bdi       = bdi_q;
    assign bdi_valid = bdi_valid_q;
    assign bdi_type  = bdi_type_q;
    assign bdi_eot   = bdi_eot_q;
    assign bdi_eoi   = bdi_eoi_q;

`ifdef ASCON_PADDER_CHECK_EN
    logic err_q, err_d;

    always_comb begin : hdr_check
        err_d = err_q;
        if (hdr_acc) begin
            if (((hdr_type == D_NONCE || hdr_type == D_TAG) && hdr_len != LEN_BITS'(16)) ||
                (hdr_type == D_TAG && hdr_eoi)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_ascon_bdi_padder.sv
// tb/tb_ascon_bdi_padder.sv - self-checking bench for ascon_bdi_padder
module tb_ascon_bdi_padder;
    import ascon_pkg::*;

    localparam int LEN_BITS = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          hdr_type;
    logic [LEN_BITS-1:0] hdr_len;
    logic                hdr_eoi, hdr_valid, hdr_ready;
    logic [7:0]          din;
    logic                din_valid, din_ready;
    logic [CCW-1:0]      bdi;
    logic                bdi_valid, bdi_ready;
    logic [3:0]          bdi_type;
    logic                bdi_eot, bdi_eoi;
`ifdef ASCON_PADDER_CHECK_EN
    logic                err;
`endif

    always #5 clk = ~clk;

    ascon_bdi_padder #(.LEN_BITS(LEN_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .hdr_type  (hdr_type),
        .hdr_len   (hdr_len),
        .hdr_eoi   (hdr_eoi),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .bdi       (bdi),
        .bdi_valid (bdi_valid),
        .bdi_ready (bdi_ready),
        .bdi_type  (bdi_type),
        .bdi_eot   (bdi_eot),
        .bdi_eoi   (bdi_eoi)
`ifdef ASCON_PADDER_CHECK_EN
        ,
        .err       (err)
`endif
    );

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  t;
        logic        eot;
        logic        eoi;
    } exp_t;

    typedef struct {
        logic [3:0]   typ;
        int           len;
        logic         eoi;
        logic [7:0]   base;
        logic [7:0]   step;
        int           nw;
        logic [127:0] words;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        mon_e, mon_got;
    vec_t        vecs[7];
    int          tests = 0;
    int          fails = 0;
    logic        rdy_rand = 1'b0;
    logic        rdy_force = 1'b1;
    logic        hold_v = 1'b0;
    logic [31:0] hold_w = '0;
    logic [3:0]  tsel[4];
    logic [3:0]  rt;
    int          rlen;

    initial begin
        bdi_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bdi_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Scoreboard: every accepted word against the expected queue, plus hold-stable checks.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                tests++;
                if (!bdi_valid || bdi !== hold_w) begin
                    fails++;
                    $display("FAIL hold: valid=%0b bdi=%h, required valid=1 bdi=%h", bdi_valid, bdi, hold_w);
                end
            end
            if (bdi_valid && bdi_ready) begin
                tests++;
                mon_got = {bdi, bdi_type, bdi_eot, bdi_eoi};
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_word: got %h, required no word", bdi);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_got !== mon_e) begin
                        fails++;
                        $display("FAIL word: got w=%h t=%0d eot=%0b eoi=%0b, required w=%h t=%0d eot=%0b eoi=%0b",
                                 mon_got.w, mon_got.t, mon_got.eot, mon_got.eoi,
                                 mon_e.w, mon_e.t, mon_e.eot, mon_e.eoi);
                    end
                end
            end
            hold_v = bdi_valid && !bdi_ready;
            hold_w = bdi;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic send_hdr(input logic [3:0] t, input int len, input logic e);
        int n = 0;
        hdr_type  = t;
        hdr_len   = LEN_BITS'(len);
        hdr_eoi   = e;
        hdr_valid = 1'b1;
        @(negedge clk);
        while (!hdr_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!hdr_ready) chk("hdr_timeout", 64'd0, 64'd1);
        tick();
        hdr_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        din       = b;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) chk("din_timeout", 64'd0, 64'd1);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_seg(input logic [3:0] t, input int len, input logic e,
                            input logic [7:0] base, input logic [7:0] step, input bit gaps);
        logic [7:0] b;
        send_hdr(t, len, e);
        b = base;
        for (int i = 0; i < len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_byte(b);
            b = b + step;
        end
    endtask

    // Reference: NONCE/TAG chunked and zero-filled; AD/MSG get 0x80 appended before chunking.
    task automatic model_seg(input logic [3:0] t, input int len, input logic e,
                             input logic [7:0] base, input logic [7:0] step);
        logic [7:0] bq[$];
        logic [7:0] b;
        exp_t       x;
        int         nw;
        if (len == 0) return;
        b = base;
        for (int i = 0; i < len; i++) begin
            bq.push_back(b);
            b = b + step;
        end
        if (!(t == D_NONCE || t == D_TAG)) bq.push_back(8'h80);
        while (bq.size() % 4 != 0) bq.push_back(8'h00);
        nw = bq.size() / 4;
        for (int i = 0; i < nw; i++) begin
            x.w   = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
            x.t   = t;
            x.eot = (i == nw - 1);
            x.eoi = (i == nw - 1) && e && (t != D_TAG);
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset(input string name);
        chk(name, {23'd0, hdr_ready, din_ready, bdi_valid, bdi_eot, bdi_eoi, bdi_type, bdi},
            {23'd0, 5'b00000, 4'(D_NULL), 32'h0});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        exp_t x;
        vecs[0] = '{D_NONCE, 16, 1'b0, 8'h00, 8'h01, 4, 128'h000102030405060708090A0B0C0D0E0F};
        vecs[1] = '{D_AD,     5, 1'b0, 8'h11, 8'h01, 2, {32'h11121314, 32'h15800000, 64'h0}};
        vecs[2] = '{D_MSG,    8, 1'b1, 8'hA0, 8'h01, 3, {32'hA0A1A2A3, 32'hA4A5A6A7, 32'h80000000, 32'h0}};
        vecs[3] = '{D_AD,     0, 1'b0, 8'h00, 8'h01, 0, 128'h0};
        vecs[4] = '{D_MSG,    3, 1'b1, 8'hAA, 8'h11, 1, {32'hAABBCC80, 96'h0}};
        vecs[5] = '{D_TAG,   16, 1'b0, 8'h30, 8'h01, 4, 128'h303132333435363738393A3B3C3D3E3F};
        vecs[6] = '{D_AD,     4, 1'b1, 8'h50, 8'h01, 2, {32'h50515253, 32'h80000000, 64'h0}};
        tsel    = '{D_NONCE, D_AD, D_MSG, D_TAG};

        rst = 1'b1;
        hdr_type = '0; hdr_len = '0; hdr_eoi = 1'b0; hdr_valid = 1'b0;
        din = '0; din_valid = 1'b0;
        tick();
        @(negedge clk);
        check_reset("reset_state");
        tick();
        rst = 1'b0;
        tick();

        // First word valid one cycle after its fourth byte.
        model_seg(D_NONCE, 16, 1'b0, 8'hC0, 8'h01);
        send_hdr(D_NONCE, 16, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        @(negedge clk);
        chk("latency_before_4th", 64'(bdi_valid), 64'd0);
        tick();
        send_byte(8'hC3);
        @(negedge clk);
        chk("latency_after_4th", {31'd0, bdi_valid, bdi}, {31'd0, 1'b1, 32'hC0C1C2C3});
        tick();
        for (int i = 4; i < 16; i++) send_byte(8'hC0 + 8'(i));
        wait_drain("latency_drain");

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].nw; i++) begin
                x.w   = vecs[v].words[127-32*i -: 32];
                x.t   = vecs[v].typ;
                x.eot = (i == vecs[v].nw - 1);
                x.eoi = (i == vecs[v].nw - 1) && vecs[v].eoi;
                exp_q.push_back(x);
            end
            send_seg(vecs[v].typ, vecs[v].len, vecs[v].eoi, vecs[v].base, vecs[v].step, 1'b0);
            wait_drain($sformatf("vec%0d_drain", v));
        end

        // Output stalled: one word in the register, four held, then din_ready must drop.
        rdy_force = 1'b0;
        tick();
        model_seg(D_MSG, 12, 1'b0, 8'h60, 8'h01);
        send_hdr(D_MSG, 12, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i));
        din       = 8'h68;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_din_ready", 64'(din_ready), 64'd0);
        end
        chk("stall_bdi_held", {31'd0, bdi_valid, bdi}, {31'd0, 1'b1, 32'h60616263});
        tick();
        din_valid = 1'b0;
        rdy_force = 1'b1;
        for (int i = 8; i < 12; i++) send_byte(8'h60 + 8'(i));
        wait_drain("stall_drain");

        // Reset mid-segment discards the partial word; a fresh NONCE follows.
        send_hdr(D_AD, 8, 1'b0);
        send_byte(8'hE1);
        send_byte(8'hE2);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_reset("reset_mid_segment");
        tick();
        rst = 1'b0;
        tick();
        model_seg(D_NONCE, 16, 1'b1, 8'h20, 8'h01);
        send_seg(D_NONCE, 16, 1'b1, 8'h20, 8'h01, 1'b0);
        wait_drain("post_reset_drain");

        rdy_rand = 1'b1;
        for (int s = 0; s < 40; s++) begin
            logic       re;
            logic [7:0] rb;
            rt = tsel[$urandom_range(0, 3)];
            if (rt == D_NONCE || rt == D_TAG)
                rlen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
            else
                rlen = int'($urandom_range(0, 13));
            re = 1'($urandom_range(0, 1));
            rb = 8'($urandom_range(0, 255));
            model_seg(rt, rlen, re, rb, 8'h07);
            send_seg(rt, rlen, re, rb, 8'h07, 1'b1);
        end
        wait_drain("random_drain");
        rdy_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
